memory_access: RTL and testbench
================================

# memory_access

Memory stage of the Dioptase pipeline, between execute and writeback. Issues data-memory requests for loads and stores, aligns store data into byte lanes, and splits misaligned word and halfword accesses into two aligned word accesses. For split loads it emits a bubble-then-instruction pair so writeback can stitch the two read words together. All other pipeline fields are registered through to writeback unchanged.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-high
- clk_en  in  1  global clock enable
- halt  in  1  freeze; the stage holds all state while asserted
- bubble_in  in  1  upstream slot is empty
- opcode_in  in  5  opcode: 3-5 word, 6-8 halfword, 9-11 byte memory ops
- is_load_in, is_store_in  in  1 each  memory-op class
- tgt_in_1, tgt_in_2  in  5 each  destination registers
- alu_result_1_in  in  32  effective address for memory ops, otherwise ALU result
- alu_result_2_in  in  32  second ALU result
- store_data  in  32  store value, right-justified
- exc_in  in  8  exception code; 0 means none
- tgts_cr_in, priv_type_in[4:0], crmov_mode_type_in[1:0]  in  pass-through fields
- stall_out  out  1  holds execute and earlier stages
- mem_addr  out  32  word-aligned address; [1:0] is always 0
- mem_ren  out  1  read strobe
- mem_wen  out  4  byte-write enables
- mem_wdata  out  32  lane-aligned write data
- bubble_out, opcode_out, is_load_out, is_store_out, tgt_out_1, tgt_out_2, alu_result_1_out, alu_result_2_out, exc_out, tgts_cr_out, priv_type_out, crmov_mode_type_out  out  registered to writeback
- is_misaligned_out  out  1  marks the first half of a split load
- addr_out  out  32  original unaligned effective address

## Operation
- off = addr[1:0]. Base mask: word 4'b1111, halfword 4'b0011, byte 4'b0001. Eight-bit lane vector m8 = mask << off.
- Misaligned access: a word op with off != 0, or a halfword op with off == 3. Byte ops are never misaligned.
- An access is active when the op is a load or store, bubble_in = 0, and exc_in = 0. Otherwise mem_ren = 0 and mem_wen = 0.
- Aligned access:
  - mem_addr = {addr[31:2], 2'b00}
  - Load: mem_ren = 1.
  - Store: mem_wen = m8[3:0]; mem_wdata = store_data << 8*off.
- FSM states: IDLE and SPLIT.
- IDLE, active and misaligned:
  - Latch address, store data, mask and all pass-through fields.
  - Issue the first half: aligned address, mem_wen = m8[3:0], mem_wdata = store_data << 8*off.
  - Assert stall_out; go to SPLIT.
  - Load: register bubble_out = 1, is_misaligned_out = 1, addr_out = addr.
  - Store: register bubble_out = 1, is_misaligned_out = 0.
- SPLIT:
  - Issue the second half from the latched copies: mem_addr = aligned + 4, mem_wen = m8[7:4], mem_wdata = store_data >> 8*(4-off).
  - Deassert stall_out.
  - Register the real instruction: bubble_out = 0, is_misaligned_out = 0, addr_out = original address.
  - Return to IDLE.
- IDLE, all other cases: register the inputs straight through. Set is_misaligned_out = 0, addr_out = alu_result_1_in, stall_out = 0.
- Exceptions: an upstream exception (exc_in != 0) passes through unchanged and performs no access.

## Timing
- Memory is synchronous with a 1-cycle read latency. Data returns in the same cycle the registered instruction reaches writeback.
- Aligned op: 1 cycle. Split op: 2 cycles, with exactly one stall cycle.
- Split load, request at cycle t:
  - At t+1, writeback sees the bubble (is_misaligned = 1) and read word 0.
  - At t+2, writeback sees the instruction and read word 1.
- Freeze: when halt = 1 or clk_en = 0, the state, output registers and latches hold, and mem_ren and mem_wen are forced to 0. stall_out keeps its value.
- Reset: asynchronous, with immediate effect, including mid-SPLIT.
  - State returns to IDLE; stall_out = 0; mem_ren = 0; mem_wen = 0.
  - bubble_out = 1; all other outputs = 0.
  - Any pending second half is abandoned.
- Upstream must hold its inputs while stall_out = 1. In SPLIT the stage ignores its inputs.

## Configuration
- MEM_MISALIGN_EXC_EN defined:
  - A misaligned access raises exc_out = 8'h04 instead of splitting.
  - No memory strobes are issued and the SPLIT state is never entered.
  - The op passes with bubble_out = 0.
- MEM_MISALIGN_EXC_EN undefined: misaligned accesses split as described in Operation.

## Test plan
- Aligned word load at 0x100 -> mem_addr = 0x100, mem_ren = 1, no stall; next cycle bubble_out = 0, is_misaligned_out = 0.
- Byte store of 0xAB at 0x203 -> mem_addr = 0x200, mem_wen = 4'b1000, mem_wdata = 0xAB000000.
- Word load at 0x101 -> cycle 1: mem_addr = 0x100, stall_out = 1, then bubble with is_misaligned_out = 1 and addr_out = 0x101. Cycle 2: mem_addr = 0x104, stall_out = 0, then instruction with bubble_out = 0.
- Halfword store of 0xBEEF at 0x3 -> mem_wen = 4'b1000 and mem_wdata = 0xEF000000 at 0x0; then mem_wen = 4'b0001 and mem_wdata = 0x000000BE at 0x4.
- Assert rst during SPLIT -> stall_out = 0, mem_wen = 0, mem_ren = 0 and bubble_out = 1 immediately; no second access afterwards.
- With MEM_MISALIGN_EXC_EN defined, word load at 0x102 -> exc_out = 8'h04, mem_ren = 0, stall_out never asserted.

Source files
------------

// File: rtl/memory_access_if.sv
// Data-memory request bus driven by the memory stage: word address, read strobe,
// byte-write enables and lane-aligned write data.
interface memory_access_if;
   logic [31:0] mem_addr;
   logic        mem_ren;
   logic [3:0]  mem_wen;
   logic [31:0] mem_wdata;

   modport master (output mem_addr, output mem_ren, output mem_wen, output mem_wdata);
   modport slave  (input  mem_addr, input  mem_ren, input  mem_wen, input  mem_wdata);
endinterface

// File: rtl/memory_access.sv
// Dioptase memory stage: issues loads/stores, aligns byte lanes, splits misaligned accesses in two.
// Build option MEM_MISALIGN_EXC_EN: misaligned accesses raise exception 8'h04 instead of splitting.
module memory_access (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clk_en,
   input  logic                   halt,
   input  logic                   bubble_in,
   input  logic [4:0]             opcode_in,
   input  logic                   is_load_in,
   input  logic                   is_store_in,
   input  logic [4:0]             tgt_in_1,
   input  logic [4:0]             tgt_in_2,
   input  logic [31:0]            alu_result_1_in,
   input  logic [31:0]            alu_result_2_in,
   input  logic [31:0]            store_data,
   input  logic [7:0]             exc_in,
   input  logic                   tgts_cr_in,
   input  logic [4:0]             priv_type_in,
   input  logic [1:0]             crmov_mode_type_in,
   output logic                   stall_out,
   memory_access_if.master        mem,
   output logic                   bubble_out,
   output logic [4:0]             opcode_out,
   output logic                   is_load_out,
   output logic                   is_store_out,
   output logic [4:0]             tgt_out_1,
   output logic [4:0]             tgt_out_2,
   output logic [31:0]            alu_result_1_out,
   output logic [31:0]            alu_result_2_out,
   output logic [7:0]             exc_out,
   output logic                   tgts_cr_out,
   output logic [4:0]             priv_type_out,
   output logic [1:0]             crmov_mode_type_out,
   output logic                   is_misaligned_out,
   output logic [31:0]            addr_out
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] SPLIT = 1'b1;

   logic [0:0]  state_reg;
   logic        run;
   logic        active;
   logic        misaligned;
   logic        split_start;
   logic        misalign_exc;
   logic [1:0]  off;
   logic [3:0]  mask;
   logic [7:0]  m8;

   // Copies of the split instruction, replayed during the second half
   logic [31:0] lat_addr;
   logic [31:0] lat_data;
   logic [7:0]  lat_m8;
   logic        lat_is_load;
   logic        lat_is_store;
   logic [4:0]  lat_opcode;
   logic [4:0]  lat_tgt_1;
   logic [4:0]  lat_tgt_2;
   logic [31:0] lat_alu_2;
   logic        lat_tgts_cr;
   logic [4:0]  lat_priv;
   logic [1:0]  lat_crmov;

   always_comb begin
      mask = 4'b0000;
      if (opcode_in >= 5'd3 && opcode_in <= 5'd5)
         mask = 4'b1111;
      else if (opcode_in >= 5'd6 && opcode_in <= 5'd8)
         mask = 4'b0011;
      else if (opcode_in >= 5'd9 && opcode_in <= 5'd11)
         mask = 4'b0001;
   end

   assign run        = clk_en & ~halt;
   assign off        = alu_result_1_in[1:0];
   assign m8         = {4'b0000, mask} << off;
   assign active     = (is_load_in | is_store_in) & ~bubble_in & (exc_in == 8'h00);
   assign misaligned = ((mask == 4'b1111) && (off != 2'd0)) ||
                       ((mask == 4'b0011) && (off == 2'd3));

`ifdef MEM_MISALIGN_EXC_EN
   assign misalign_exc = (state_reg == IDLE) && active && misaligned;
   assign split_start  = 1'b0;
`else
   assign misalign_exc = 1'b0;
   assign split_start  = (state_reg == IDLE) && active && misaligned;
`endif

   always_comb begin
      mem.mem_addr  = {alu_result_1_in[31:2], 2'b00};
      mem.mem_ren   = 1'b0;
      mem.mem_wen   = 4'b0000;
      mem.mem_wdata = store_data << {off, 3'b000};
      stall_out     = 1'b0;
      if (state_reg == SPLIT) begin
         mem.mem_addr  = {lat_addr[31:2], 2'b00} + 32'd4;
         mem.mem_ren   = lat_is_load;
         mem.mem_wen   = lat_is_store ? lat_m8[7:4] : 4'b0000;
         // Upper lanes carry the bytes that spilled past the first word
         mem.mem_wdata = lat_data >> (6'd32 - {1'b0, lat_addr[1:0], 3'b000});
      end else if (active && !misalign_exc) begin
         mem.mem_ren = is_load_in;
         mem.mem_wen = is_store_in ? m8[3:0] : 4'b0000;
         stall_out   = split_start;
      end
      if (!run) begin
         mem.mem_ren = 1'b0;
         mem.mem_wen = 4'b0000;
      end
      if (rst) begin
         mem.mem_ren = 1'b0;
         mem.mem_wen = 4'b0000;
         stall_out   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg           <= IDLE;
         bubble_out          <= 1'b1;
         opcode_out          <= '0;
         is_load_out         <= 1'b0;
         is_store_out        <= 1'b0;
         tgt_out_1           <= '0;
         tgt_out_2           <= '0;
         alu_result_1_out    <= '0;
         alu_result_2_out    <= '0;
         exc_out             <= '0;
         tgts_cr_out         <= 1'b0;
         priv_type_out       <= '0;
         crmov_mode_type_out <= '0;
         is_misaligned_out   <= 1'b0;
         addr_out            <= '0;
         lat_addr            <= '0;
         lat_data            <= '0;
         lat_m8              <= '0;
         lat_is_load         <= 1'b0;
         lat_is_store        <= 1'b0;
         lat_opcode          <= '0;
         lat_tgt_1           <= '0;
         lat_tgt_2           <= '0;
         lat_alu_2           <= '0;
         lat_tgts_cr         <= 1'b0;
         lat_priv            <= '0;
         lat_crmov           <= '0;
      end else if (run) begin
         if (state_reg == SPLIT) begin
            bubble_out          <= 1'b0;
            opcode_out          <= lat_opcode;
            is_load_out         <= lat_is_load;
            is_store_out        <= lat_is_store;
            tgt_out_1           <= lat_tgt_1;
            tgt_out_2           <= lat_tgt_2;
            alu_result_1_out    <= lat_addr;
            alu_result_2_out    <= lat_alu_2;
            exc_out             <= 8'h00;
            tgts_cr_out         <= lat_tgts_cr;
            priv_type_out       <= lat_priv;
            crmov_mode_type_out <= lat_crmov;
            is_misaligned_out   <= 1'b0;
            addr_out            <= lat_addr;
            state_reg           <= IDLE;
         end else begin
            bubble_out          <= bubble_in;
            opcode_out          <= opcode_in;
            is_load_out         <= is_load_in;
            is_store_out        <= is_store_in;
            tgt_out_1           <= tgt_in_1;
            tgt_out_2           <= tgt_in_2;
            alu_result_1_out    <= alu_result_1_in;
            alu_result_2_out    <= alu_result_2_in;
            exc_out             <= exc_in;
            tgts_cr_out         <= tgts_cr_in;
            priv_type_out       <= priv_type_in;
            crmov_mode_type_out <= crmov_mode_type_in;
            is_misaligned_out   <= 1'b0;
            addr_out            <= alu_result_1_in;
            if (misalign_exc)
               exc_out <= 8'h04;
            if (split_start) begin
               bubble_out        <= 1'b1;
               is_misaligned_out <= is_load_in;
               lat_addr          <= alu_result_1_in;
               lat_data          <= store_data;
               lat_m8            <= m8;
               lat_is_load       <= is_load_in;
               lat_is_store      <= is_store_in;
               lat_opcode        <= opcode_in;
               lat_tgt_1         <= tgt_in_1;
               lat_tgt_2         <= tgt_in_2;
               lat_alu_2         <= alu_result_2_in;
               lat_tgts_cr       <= tgts_cr_in;
               lat_priv          <= priv_type_in;
               lat_crmov         <= crmov_mode_type_in;
               state_reg         <= SPLIT;
            end
         end
      end
   end

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: aligned, split, freeze, reset and exception scenarios.
module tb_memory_access;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        clk_en, halt, bubble_in, is_load_in, is_store_in, tgts_cr_in;
   logic [4:0]  opcode_in, tgt_in_1, tgt_in_2, priv_type_in;
   logic [31:0] alu_result_1_in, alu_result_2_in, store_data;
   logic [7:0]  exc_in;
   logic [1:0]  crmov_mode_type_in;
   logic        stall_out, bubble_out, is_load_out, is_store_out, tgts_cr_out, is_misaligned_out;
   logic [4:0]  opcode_out, tgt_out_1, tgt_out_2, priv_type_out;
   logic [31:0] alu_result_1_out, alu_result_2_out, addr_out;
   logic [7:0]  exc_out;
   logic [1:0]  crmov_mode_type_out;
   int errors = 0;
   int checks = 0;

   memory_access_if mem();

   memory_access dut (
      .clk(clk), .rst(rst), .clk_en(clk_en), .halt(halt), .bubble_in(bubble_in),
      .opcode_in(opcode_in), .is_load_in(is_load_in), .is_store_in(is_store_in),
      .tgt_in_1(tgt_in_1), .tgt_in_2(tgt_in_2), .alu_result_1_in(alu_result_1_in),
      .alu_result_2_in(alu_result_2_in), .store_data(store_data), .exc_in(exc_in),
      .tgts_cr_in(tgts_cr_in), .priv_type_in(priv_type_in), .crmov_mode_type_in(crmov_mode_type_in),
      .stall_out(stall_out), .mem(mem), .bubble_out(bubble_out), .opcode_out(opcode_out),
      .is_load_out(is_load_out), .is_store_out(is_store_out), .tgt_out_1(tgt_out_1),
      .tgt_out_2(tgt_out_2), .alu_result_1_out(alu_result_1_out), .alu_result_2_out(alu_result_2_out),
      .exc_out(exc_out), .tgts_cr_out(tgts_cr_out), .priv_type_out(priv_type_out),
      .crmov_mode_type_out(crmov_mode_type_out), .is_misaligned_out(is_misaligned_out),
      .addr_out(addr_out)
   );

   always #5 clk = ~clk;

   task automatic set_op(input logic ld, input logic st, input logic [4:0] op,
                         input logic [31:0] addr, input logic [31:0] data);
      bubble_in = 1'b0; is_load_in = ld; is_store_in = st; opcode_in = op;
      alu_result_1_in = addr; store_data = data; exc_in = 8'h00;
   endtask

   task automatic set_idle();
      bubble_in = 1'b1; is_load_in = 1'b0; is_store_in = 1'b0; opcode_in = 5'd0;
      alu_result_1_in = 32'h0; store_data = 32'h0; exc_in = 8'h00;
   endtask

   task automatic test_reset();
      set_idle(); clk_en = 1'b1; halt = 1'b0;
      tgt_in_1 = 5'd0; tgt_in_2 = 5'd0; alu_result_2_in = 32'h0;
      tgts_cr_in = 1'b0; priv_type_in = 5'd0; crmov_mode_type_in = 2'd0;
      #2 rst = 1'b1;
      #1;
      checks++; if (bubble_out !== 1'b1) begin errors++; $display("FAIL reset bubble_out: got %b want 1", bubble_out); end
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset stall_out: got %b want 0", stall_out); end
      checks++; if (mem.mem_ren !== 1'b0 || mem.mem_wen !== 4'h0) begin errors++; $display("FAIL reset strobes: got ren=%b wen=%b want 0/0", mem.mem_ren, mem.mem_wen); end
      checks++; if (addr_out !== 32'h0 || exc_out !== 8'h0) begin errors++; $display("FAIL reset regs: got addr_out=%h exc_out=%h want 0/0", addr_out, exc_out); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      $display("reset: bubble_out=%b stall=%b", bubble_out, stall_out);
   endtask

   task automatic test_aligned_load();
      @(negedge clk);
      set_op(1'b1, 1'b0, 5'd3, 32'h100, 32'h0); tgt_in_1 = 5'd7; priv_type_in = 5'd9;
      #1;
      checks++; if (mem.mem_addr !== 32'h100) begin errors++; $display("FAIL aligned_load addr: got %h want 00000100", mem.mem_addr); end
      checks++; if (mem.mem_ren !== 1'b1 || mem.mem_wen !== 4'h0) begin errors++; $display("FAIL aligned_load strobes: got ren=%b wen=%b want 1/0000", mem.mem_ren, mem.mem_wen); end
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL aligned_load stall: got %b want 0", stall_out); end
      @(posedge clk); #1;
      checks++; if (bubble_out !== 1'b0 || is_misaligned_out !== 1'b0) begin errors++; $display("FAIL aligned_load wb: got bubble=%b mis=%b want 0/0", bubble_out, is_misaligned_out); end
      checks++; if (tgt_out_1 !== 5'd7 || priv_type_out !== 5'd9 || addr_out !== 32'h100) begin errors++; $display("FAIL aligned_load pass: got tgt=%0d priv=%0d addr=%h want 7/9/00000100", tgt_out_1, priv_type_out, addr_out); end
      $display("aligned_load: addr=%h bubble_out=%b", addr_out, bubble_out);
   endtask

   task automatic test_byte_store();
      @(negedge clk);
      set_op(1'b0, 1'b1, 5'd9, 32'h203, 32'h0000_00AB);
      #1;
      checks++; if (mem.mem_addr !== 32'h200) begin errors++; $display("FAIL byte_store addr: got %h want 00000200", mem.mem_addr); end
      checks++; if (mem.mem_wen !== 4'b1000 || mem.mem_ren !== 1'b0) begin errors++; $display("FAIL byte_store strobes: got wen=%b ren=%b want 1000/0", mem.mem_wen, mem.mem_ren); end
      checks++; if (mem.mem_wdata !== 32'hAB00_0000) begin errors++; $display("FAIL byte_store wdata: got %h want ab000000", mem.mem_wdata); end
      @(posedge clk); #1;
      checks++; if (is_store_out !== 1'b1 || bubble_out !== 1'b0) begin errors++; $display("FAIL byte_store wb: got store=%b bubble=%b want 1/0", is_store_out, bubble_out); end
      $display("byte_store: wen=1000 wdata=ab000000 checked");
   endtask

   task automatic test_split_load();
      @(negedge clk);
      set_op(1'b1, 1'b0, 5'd4, 32'h101, 32'h0); tgt_in_1 = 5'd12;
      #1;
      checks++; if (mem.mem_addr !== 32'h100 || mem.mem_ren !== 1'b1) begin errors++; $display("FAIL split_load first: got addr=%h ren=%b want 00000100/1", mem.mem_addr, mem.mem_ren); end
      checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL split_load stall1: got %b want 1", stall_out); end
      @(posedge clk); #1;
      checks++; if (bubble_out !== 1'b1 || is_misaligned_out !== 1'b1 || addr_out !== 32'h101) begin errors++; $display("FAIL split_load wb1: got bubble=%b mis=%b addr=%h want 1/1/00000101", bubble_out, is_misaligned_out, addr_out); end
      @(negedge clk); #1;
      checks++; if (mem.mem_addr !== 32'h104 || mem.mem_ren !== 1'b1) begin errors++; $display("FAIL split_load second: got addr=%h ren=%b want 00000104/1", mem.mem_addr, mem.mem_ren); end
      checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL split_load stall2: got %b want 0", stall_out); end
      @(posedge clk); #1;
      checks++; if (bubble_out !== 1'b0 || is_misaligned_out !== 1'b0 || addr_out !== 32'h101 || tgt_out_1 !== 5'd12) begin errors++; $display("FAIL split_load wb2: got bubble=%b mis=%b addr=%h tgt=%0d want 0/0/00000101/12", bubble_out, is_misaligned_out, addr_out, tgt_out_1); end
      @(negedge clk); set_idle();
      $display("split_load: two halves at 100/104 checked");
   endtask

   task automatic test_split_store();
      @(negedge clk);
      set_op(1'b0, 1'b1, 5'd7, 32'h3, 32'h0000_BEEF);
      #1;
      checks++; if (mem.mem_addr !== 32'h0 || mem.mem_wen !== 4'b1000 || mem.mem_wdata !== 32'hEF00_0000) begin errors++; $display("FAIL split_store first: got addr=%h wen=%b wdata=%h want 00000000/1000/ef000000", mem.mem_addr, mem.mem_wen, mem.mem_wdata); end
      @(posedge clk); #1;
      checks++; if (bubble_out !== 1'b1 || is_misaligned_out !== 1'b0) begin errors++; $display("FAIL split_store wb1: got bubble=%b mis=%b want 1/0", bubble_out, is_misaligned_out); end
      @(negedge clk); #1;
      checks++; if (mem.mem_addr !== 32'h4 || mem.mem_wen !== 4'b0001 || mem.mem_wdata !== 32'h0000_00BE) begin errors++; $display("FAIL split_store second: got addr=%h wen=%b wdata=%h want 00000004/0001/000000be", mem.mem_addr, mem.mem_wen, mem.mem_wdata); end
      @(posedge clk); #1;
      checks++; if (bubble_out !== 1'b0 || is_store_out !== 1'b1) begin errors++; $display("FAIL split_store wb2: got bubble=%b store=%b want 0/1", bubble_out, is_store_out); end
      @(negedge clk); set_idle();
      $display("split_store: halves at 0/4 checked");
   endtask

   task automatic test_reset_mid_split();
      @(negedge clk);
      set_op(1'b0, 1'b1, 5'd3, 32'h2, 32'h1122_3344);
      @(posedge clk);
      @(negedge clk); #1;
      checks++; if (mem.mem_wen !== 4'b0011 || mem.mem_wdata !== 32'h0000_1122) begin errors++; $display("FAIL rst_split pre: got wen=%b wdata=%h want 0011/00001122", mem.mem_wen, mem.mem_wdata); end
      rst = 1'b1; set_idle();
      #1;
      checks++; if (stall_out !== 1'b0 || mem.mem_wen !== 4'h0 || mem.mem_ren !== 1'b0) begin errors++; $display("FAIL rst_split strobes: got stall=%b wen=%b ren=%b want 0/0000/0", stall_out, mem.mem_wen, mem.mem_ren); end
      checks++; if (bubble_out !== 1'b1) begin errors++; $display("FAIL rst_split bubble: got %b want 1", bubble_out); end
      @(negedge clk); rst = 1'b0;
      #1;
      checks++; if (mem.mem_wen !== 4'h0 || mem.mem_ren !== 1'b0) begin errors++; $display("FAIL rst_split after: got wen=%b ren=%b want 0000/0", mem.mem_wen, mem.mem_ren); end
      @(posedge clk); @(negedge clk); #1;
      checks++; if (mem.mem_wen !== 4'h0 || bubble_out !== 1'b1) begin errors++; $display("FAIL rst_split abandoned: got wen=%b bubble=%b want 0000/1", mem.mem_wen, bubble_out); end
      $display("reset_mid_split: second half abandoned");
   endtask

   task automatic test_freeze();
      @(negedge clk);
      set_op(1'b1, 1'b0, 5'd3, 32'h100, 32'h0); halt = 1'b1;
      #1;
      checks++; if (mem.mem_ren !== 1'b0) begin errors++; $display("FAIL freeze_halt ren: got %b want 0", mem.mem_ren); end
      @(posedge clk); #1;
      checks++; if (bubble_out !== 1'b1) begin errors++; $display("FAIL freeze_halt hold: got bubble=%b want 1", bubble_out); end
      @(negedge clk); halt = 1'b0; clk_en = 1'b0;
      @(posedge clk); #1;
      checks++; if (bubble_out !== 1'b1 || mem.mem_ren !== 1'b0) begin errors++; $display("FAIL freeze_clken hold: got bubble=%b ren=%b want 1/0", bubble_out, mem.mem_ren); end
      @(negedge clk); clk_en = 1'b1;
      set_op(1'b1, 1'b0, 5'd3, 32'h101, 32'h0);
      @(posedge clk);
      @(negedge clk); halt = 1'b1; #1;
      checks++; if (mem.mem_ren !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL freeze_split strobe: got ren=%b stall=%b want 0/0", mem.mem_ren, stall_out); end
      @(posedge clk); #1;
      checks++; if (bubble_out !== 1'b1 || is_misaligned_out !== 1'b1) begin errors++; $display("FAIL freeze_split hold: got bubble=%b mis=%b want 1/1", bubble_out, is_misaligned_out); end
      @(negedge clk); halt = 1'b0; #1;
      checks++; if (mem.mem_addr !== 32'h104 || mem.mem_ren !== 1'b1) begin errors++; $display("FAIL freeze_split resume: got addr=%h ren=%b want 00000104/1", mem.mem_addr, mem.mem_ren); end
      @(posedge clk); #1;
      checks++; if (bubble_out !== 1'b0) begin errors++; $display("FAIL freeze_split done: got bubble=%b want 0", bubble_out); end
      @(negedge clk); set_idle();
      $display("freeze: halt and clk_en hold checked");
   endtask

   task automatic test_exception();
      @(negedge clk);
      set_op(1'b1, 1'b0, 5'd3, 32'h101, 32'h0); exc_in = 8'h07;
      #1;
      checks++; if (mem.mem_ren !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL exc_pass strobe: got ren=%b stall=%b want 0/0", mem.mem_ren, stall_out); end
      @(posedge clk); #1;
      checks++; if (exc_out !== 8'h07 || bubble_out !== 1'b0) begin errors++; $display("FAIL exc_pass wb: got exc=%h bubble=%b want 07/0", exc_out, bubble_out); end
      @(negedge clk); set_idle();
      $display("exception: passthrough exc=%h", exc_out);
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      set_op(1'b0, 1'b1, 5'd5, 32'h10, 32'hDEAD_BEEF);
      #1;
      checks++; if (mem.mem_wen !== 4'b1111 || mem.mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b store: got wen=%b wdata=%h want 1111/deadbeef", mem.mem_wen, mem.mem_wdata); end
      @(negedge clk);
      set_op(1'b1, 1'b0, 5'd6, 32'h22, 32'h0);
      #1;
      checks++; if (mem.mem_addr !== 32'h20 || mem.mem_ren !== 1'b1 || stall_out !== 1'b0) begin errors++; $display("FAIL b2b half_load: got addr=%h ren=%b stall=%b want 00000020/1/0", mem.mem_addr, mem.mem_ren, stall_out); end
      checks++; if (is_store_out !== 1'b1 || addr_out !== 32'h10) begin errors++; $display("FAIL b2b wb_store: got store=%b addr=%h want 1/00000010", is_store_out, addr_out); end
      @(posedge clk); #1;
      checks++; if (is_load_out !== 1'b1 || addr_out !== 32'h22 || is_misaligned_out !== 1'b0) begin errors++; $display("FAIL b2b wb_load: got load=%b addr=%h mis=%b want 1/00000022/0", is_load_out, addr_out, is_misaligned_out); end
      @(negedge clk); set_idle();
      $display("back_to_back: store then halfword load");
   endtask

   task automatic test_misalign_exc();
      @(negedge clk);
      set_op(1'b1, 1'b0, 5'd3, 32'h102, 32'h0);
      #1;
      checks++; if (mem.mem_ren !== 1'b0 || stall_out !== 1'b0) begin errors++; $display("FAIL misalign_exc strobe: got ren=%b stall=%b want 0/0", mem.mem_ren, stall_out); end
      @(posedge clk); #1;
      checks++; if (exc_out !== 8'h04 || bubble_out !== 1'b0) begin errors++; $display("FAIL misalign_exc wb: got exc=%h bubble=%b want 04/0", exc_out, bubble_out); end
      @(negedge clk); #1;
      checks++; if (stall_out !== 1'b0 || mem.mem_ren !== 1'b0) begin errors++; $display("FAIL misalign_exc nosplit: got stall=%b ren=%b want 0/0", stall_out, mem.mem_ren); end
      set_idle();
      $display("misalign_exc: exc=%h", exc_out);
   endtask

   initial begin
      test_reset();
      test_aligned_load();
      test_byte_store();
`ifdef MEM_MISALIGN_EXC_EN
      test_misalign_exc();
`else
      test_split_load();
      test_split_store();
      test_reset_mid_split();
      test_freeze();
`endif
      test_exception();
      test_back_to_back();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: got no finish want finish before 20000");
      $fatal(1, "timeout");
   end
endmodule
